// File: rtl/fxp_divider_scaled_if.sv
// Operand/result bus for fxp_divider_scaled: a request channel (x, y, gain)
// and a response channel (q_o, r_o, flags), plus the busy status bit.
interface fxp_divider_scaled_if #(
  parameter int WIDTH  = 10,
  parameter int GAIN_W = 16,
  parameter int OUT_W  = 16
);
  // Handshake: a request transfers on a rising clk edge where in_valid && in_ready.
  // A response transfers on an edge where out_valid && out_ready. While out_valid
  // is high, q_o, r_o, dbz, ovf and sat stay stable. out_ready is ignored while
  // out_valid is low. in_valid is ignored while in_ready is low.
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic [GAIN_W-1:0] gain;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  q_o;
  logic [WIDTH-1:0]  r_o;
  logic              busy;
  logic              dbz;
  logic              ovf;
  logic              sat;

  modport master (
    output in_valid, x, y, gain, out_ready,
    input  in_ready, out_valid, q_o, r_o, busy, dbz, ovf, sat
  );

  modport slave (
    input  in_valid, x, y, gain, out_ready,
    output in_ready, out_valid, q_o, r_o, busy, dbz, ovf, sat
  );
endinterface

// File: rtl/fxp_divider_scaled.sv
// Fixed-point restoring divider (one quotient bit per cycle) followed by gain
// scaling and saturation to OUT_W. Optional two's complement operands.
module fxp_divider_scaled #(
  parameter int WIDTH  = 10,
  parameter int FBITS  = 4,
  parameter int GAIN_W = 16,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fxp_divider_scaled_if.slave  bus,
  output logic [1:0]           state_dbg
);
  localparam int ITER  = WIDTH + FBITS;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int PW    = WIDTH + GAIN_W;

  localparam logic [ITER:0] Q_ONE   = (ITER+1)'(1);
  localparam logic [ITER:0] Q_LIM_U = Q_ONE << WIDTH;
  localparam logic [ITER:0] Q_LIM_P = (Q_ONE << (WIDTH-1)) - Q_ONE;
  localparam logic [ITER:0] Q_LIM_N = Q_ONE << (WIDTH-1);

  localparam logic [PW:0] S_ONE   = (PW+1)'(1);
  localparam logic [PW:0] S_LIM_U = (S_ONE << OUT_W) - S_ONE;
  localparam logic [PW:0] S_LIM_P = (S_ONE << (OUT_W-1)) - S_ONE;
  localparam logic [PW:0] S_LIM_N = S_ONE << (OUT_W-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [ITER-1:0]    quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvs;
  logic [GAIN_W-1:0]  gain_r;
  logic               q_neg;
  logic               r_neg;
  logic [CNT_W-1:0]   cnt;

  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               dbz_r;
  logic               ovf_r;
  logic               sat_r;
  logic [OUT_W-1:0]   q_r;
  logic [WIDTH-1:0]   r_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;
  assign bus.sat       = sat_r;
  assign bus.q_o       = q_r;
  assign bus.r_o       = r_r;
  assign state_dbg     = state;

  // Operand magnitudes; |-2^(WIDTH-1)| still fits WIDTH bits as unsigned.
  logic             x_neg, y_neg;
  logic [WIDTH-1:0] x_abs, y_abs;

  assign x_neg = (SIGNED != 0) && bus.x[WIDTH-1];
  assign y_neg = (SIGNED != 0) && bus.y[WIDTH-1];
  assign x_abs = x_neg ? -bus.x : bus.x;
  assign y_abs = y_neg ? -bus.y : bus.y;

  // One restoring step: dividend bits leave quo at the top, quotient bits enter at the bottom.
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    trial    = {rem, quo[ITER-1]};
    take     = (trial >= {1'b0, dvs});
    rem_next = take ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
  end

  logic [ITER:0]    q_ext;
  logic             ovf_c;
  logic [PW-1:0]    prod;
  logic [PW:0]      s_ext;
  logic [PW:0]      s_lim;
  logic             sat_c;
  logic [OUT_W-1:0] mag;
  logic [OUT_W-1:0] q_c;
  logic [WIDTH-1:0] r_c;

  always_comb begin
    q_ext = {1'b0, quo};
    if (SIGNED == 0) ovf_c = (q_ext >= Q_LIM_U);
    else             ovf_c = q_neg ? (q_ext > Q_LIM_N) : (q_ext > Q_LIM_P);

    prod  = PW'(quo[WIDTH-1:0]) * PW'(gain_r);
    s_ext = {1'b0, prod >> FBITS};
    if (SIGNED == 0) s_lim = S_LIM_U;
    else             s_lim = q_neg ? S_LIM_N : S_LIM_P;
    sat_c = (s_ext > s_lim);

    // Clamp on magnitude first, then apply the sign.
    mag = sat_c ? OUT_W'(s_lim) : OUT_W'(s_ext);
    q_c = q_neg ? -mag : mag;
    r_c = r_neg ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      gain_r      <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      sat_r       <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            quo        <= ITER'(x_abs) << FBITS;
            rem        <= '0;
            dvs        <= y_abs;
            gain_r     <= bus.gain;
            q_neg      <= x_neg ^ y_neg;
            r_neg      <= x_neg;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            dbz_r      <= 1'b0;
            ovf_r      <= 1'b0;
            sat_r      <= 1'b0;
            if (bus.y == '0) begin
              dbz_r <= 1'b1;
              q_r   <= '0;
              r_r   <= '0;
              state <= DONE;
            end else begin
              busy_r <= 1'b1;
              state  <= DIV;
            end
          end
        end
        DIV: begin
          quo <= {quo[ITER-2:0], take};
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER-1)) state <= SCALE;
        end
        SCALE: begin
          busy_r      <= 1'b0;
          out_valid_r <= 1'b1;
          state       <= DONE;
          if (ovf_c) begin
            ovf_r <= 1'b1;
            q_r   <= '0;
            r_r   <= '0;
          end else begin
            sat_r <= sat_c;
            q_r   <= q_c;
            r_r   <= r_c;
          end
        end
        DONE: begin
          // The divide-by-zero path arrives with out_valid low and raises it one cycle later.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fxp_divider_scaled.sv
// Bench for fxp_divider_scaled: an unsigned and a signed instance share stimulus,
// results are compared against an integer-arithmetic reference model.
module tb_fxp_divider_scaled;
  localparam int W    = 10;
  localparam int FB   = 4;
  localparam int GW   = 16;
  localparam int OW   = 16;
  localparam int ITER = W + FB;

  typedef struct packed {
    logic [OW-1:0] q;
    logic [W-1:0]  r;
    logic          dbz;
    logic          ovf;
    logic          sat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic          sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic [GW-1:0] gain = '0;

  logic [W+OW+2:0] exp_q[$];

  fxp_divider_scaled_if #(.WIDTH(W), .GAIN_W(GW), .OUT_W(OW)) bif_u ();
  fxp_divider_scaled_if #(.WIDTH(W), .GAIN_W(GW), .OUT_W(OW)) bif_s ();
  logic [1:0] st_u, st_s;

  fxp_divider_scaled #(.WIDTH(W), .FBITS(FB), .GAIN_W(GW), .OUT_W(OW), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .bus(bif_u), .state_dbg(st_u));
  fxp_divider_scaled #(.WIDTH(W), .FBITS(FB), .GAIN_W(GW), .OUT_W(OW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bif_s), .state_dbg(st_s));

  assign bif_u.in_valid  = in_valid & ~sel;
  assign bif_s.in_valid  = in_valid & sel;
  assign bif_u.out_ready = out_ready;
  assign bif_s.out_ready = out_ready;
  assign bif_u.x = x;
  assign bif_s.x = x;
  assign bif_u.y = y;
  assign bif_s.y = y;
  assign bif_u.gain = gain;
  assign bif_s.gain = gain;

  logic obs_in_ready, obs_out_valid, obs_busy;
  logic [1:0] obs_state;
  res_t obs;
  assign obs_in_ready  = sel ? bif_s.in_ready  : bif_u.in_ready;
  assign obs_out_valid = sel ? bif_s.out_valid : bif_u.out_valid;
  assign obs_busy      = sel ? bif_s.busy      : bif_u.busy;
  assign obs_state     = sel ? st_s : st_u;
  assign obs = sel ? {bif_s.q_o, bif_s.r_o, bif_s.dbz, bif_s.ovf, bif_s.sat}
                   : {bif_u.q_o, bif_u.r_o, bif_u.dbz, bif_u.ovf, bif_u.sat};

  // Reference: exact integer division of x*2^FB by y, then gain, truncation and clamp.
  function automatic res_t model(input bit s, input logic [W-1:0] xv, input logic [W-1:0] yv,
                                 input logic [GW-1:0] gv);
    longint xi, yi, ax, ay, qq, rr, sc, lim;
    bit neg, rneg;
    res_t e;
    e = '0;
    if (s) begin
      xi = longint'($signed(xv));
      yi = longint'($signed(yv));
    end else begin
      xi = longint'(xv);
      yi = longint'(yv);
    end
    if (yi == 0) begin
      e.dbz = 1'b1;
      return e;
    end
    ax = (xi < 0) ? -xi : xi;
    ay = (yi < 0) ? -yi : yi;
    qq = (ax * (longint'(1) << FB)) / ay;
    rr = (ax * (longint'(1) << FB)) % ay;
    neg  = (xi < 0) != (yi < 0);
    rneg = (xi < 0);
    if (s ? (neg ? (qq > (longint'(1) << (W-1))) : (qq > (longint'(1) << (W-1)) - 1))
          : (qq >= (longint'(1) << W))) begin
      e.ovf = 1'b1;
      return e;
    end
    sc  = (qq * longint'(gv)) / (longint'(1) << FB);
    lim = s ? (neg ? (longint'(1) << (OW-1)) : (longint'(1) << (OW-1)) - 1)
            : (longint'(1) << OW) - 1;
    if (sc > lim) begin
      e.sat = 1'b1;
      sc = lim;
    end
    e.q = OW'(neg ? -sc : sc);
    e.r = W'(rneg ? -rr : rr);
    return e;
  endfunction

  task automatic start_op(input bit s, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [GW-1:0] gv, output int acc);
    int n;
    n = 0;
    sel = s;
    #0;
    while (!obs_in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!obs_in_ready) begin
      checks++; errors++;
      $display("FAIL start_timeout in_ready=%b want 1", obs_in_ready);
    end
    x = xv; y = yv; gain = gv; in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); gain = GW'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!obs_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!obs_out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout out_valid=%b want 1", obs_out_valid);
    end
  endtask

  task automatic finish_op(input bit keep_ready);
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (!keep_ready) out_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready[%0d] got %b want 1", s, obs_in_ready); end
      checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid[%0d] got %b want 0", s, obs_out_valid); end
      checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL rst_busy[%0d] got %b want 0", s, obs_busy); end
      checks++; if (obs !== res_t'(0)) begin errors++; $display("FAIL rst_outputs[%0d] got %h want 0", s, obs); end
      checks++; if (obs_state !== 2'd0) begin errors++; $display("FAIL rst_state[%0d] got %0d want 0", s, obs_state); end
    end
  endtask

  task automatic test_unsigned_directed();
    logic [W-1:0]  xs[9]   = '{100, 7, 1000, 50, 1023, 0, 1, 63, 64};
    logic [W-1:0]  ys[9]   = '{8, 3, 1, 1, 1023, 5, 1023, 1, 1};
    logic [GW-1:0] gs[9]   = '{16, 16, 16, 4000, 65535, 100, 16, 16, 16};
    logic [OW-1:0] want[9] = '{200, 37, 0, 16'hFFFF, 16'hFFFF, 0, 0, 1008, 0};
    int acc, lat;
    res_t e;
    for (int i = 0; i < 9; i++) begin
      e = model(1'b0, xs[i], ys[i], gs[i]);
      start_op(1'b0, xs[i], ys[i], gs[i], acc);
      wait_result(lat);
      checks++; if (lat != ITER + 1) begin errors++; $display("FAIL udir_latency[%0d] got %0d want %0d", i, lat, ITER + 1); end
      checks++; if (obs !== e) begin errors++; $display("FAIL udir_result[%0d] q,r,dbz,ovf,sat got %h want %h", i, obs, e); end
      checks++; if (obs.q !== want[i]) begin errors++; $display("FAIL udir_q[%0d] got %h want %h", i, obs.q, want[i]); end
      finish_op(1'b0);
    end
  endtask

  task automatic test_backpressure();
    int acc, lat;
    res_t e, held;
    e = model(1'b0, 10'd7, 10'd3, 16'd16);
    start_op(1'b0, 10'd7, 10'd3, 16'd16, acc);
    wait_result(lat);
    held = obs;
    checks++; if (held !== e) begin errors++; $display("FAIL bp_result got %h want %h", held, e); end
    checks++; if (held.r !== 10'd1) begin errors++; $display("FAIL bp_r got %0d want 1", held.r); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; x = 10'd900; y = 10'd2; gain = 16'd9;
      @(posedge clk); #1;
      checks++; if (obs !== e) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", i, obs, e); end
      checks++; if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_flow[%0d] in_ready=%b out_valid=%b want 0 1", i, obs_in_ready, obs_out_valid);
      end
    end
    in_valid = 1'b0;
    finish_op(1'b0);
    checks++; if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0 1", obs_out_valid, obs_in_ready);
    end
  endtask

  task automatic test_dbz();
    int acc, lat;
    res_t e;
    e = model(1'b0, 10'd123, 10'd0, 16'd77);
    start_op(1'b0, 10'd123, 10'd0, 16'd77, acc);
    wait_result(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
    checks++; if (obs !== e || e.dbz !== 1'b1) begin errors++; $display("FAIL dbz_result got %h want %h", obs, e); end
    finish_op(1'b0);
    e = model(1'b0, 10'd100, 10'd8, 16'd16);
    start_op(1'b0, 10'd100, 10'd8, 16'd16, acc);
    wait_result(lat);
    checks++; if (obs !== e) begin errors++; $display("FAIL dbz_next_result got %h want %h", obs, e); end
    finish_op(1'b0);
  endtask

  task automatic test_signed();
    logic [W-1:0]  xs[10]   = '{W'(-100), W'(-7), W'(-32), 10'd32, 10'd511, W'(-512), 10'd30, W'(-30), 10'd100, W'(-100)};
    logic [W-1:0]  ys[10]   = '{10'd8, 10'd3, 10'd1, 10'd1, 10'd16, 10'd1, 10'd1, 10'd1, W'(-8), W'(-8)};
    logic [GW-1:0] gs[10]   = '{16, 16, 16, 16, 16, 16, 4000, 4000, 16, 16};
    logic [OW-1:0] want[10] = '{16'hFF38, 16'hFFDB, 16'hFE00, 0, 16'h01FF, 0, 16'h7FFF, 16'h8000, 16'hFF38, 16'h00C8};
    int acc, lat;
    res_t e;
    for (int i = 0; i < 10; i++) begin
      e = model(1'b1, xs[i], ys[i], gs[i]);
      start_op(1'b1, xs[i], ys[i], gs[i], acc);
      wait_result(lat);
      checks++; if (obs !== e) begin errors++; $display("FAIL sdir_result[%0d] q,r,dbz,ovf,sat got %h want %h", i, obs, e); end
      checks++; if (obs.q !== want[i]) begin errors++; $display("FAIL sdir_q[%0d] got %h want %h", i, obs.q, want[i]); end
      finish_op(1'b0);
    end
    checks++; if (model(1'b1, W'(-7), 10'd3, 16'd16).r !== 10'h3FF) begin
      errors++; $display("FAIL sdir_model_r got %h want 3ff", model(1'b1, W'(-7), 10'd3, 16'd16).r);
    end
  endtask

  task automatic test_random();
    int acc, lat, hold;
    bit s;
    logic [W-1:0] xv, yv;
    logic [GW-1:0] gv;
    res_t e;
    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      xv = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 63));
      yv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 1023));
      gv = GW'($urandom);
      exp_q.push_back(model(s, xv, yv, gv));
      start_op(s, xv, yv, gv, acc);
      wait_result(lat);
      e = res_t'(exp_q.pop_front());
      checks++; if (obs !== e) begin
        errors++; $display("FAIL rnd_result[%0d] s=%0d x=%h y=%h g=%h got %h want %h", i, s, xv, yv, gv, obs, e);
      end
      checks++; if (lat != (e.dbz ? 1 : ITER + 1)) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", i, lat, e.dbz ? 1 : ITER + 1); end
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(posedge clk); #1; end
      finish_op(1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit rose;
    start_op(1'b0, 10'd100, 10'd8, 16'd16, acc);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", obs_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (obs_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async in_ready=%b busy=%b want 1 0", obs_in_ready, obs_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (obs_out_valid) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL midrst_no_result out_valid rose=%b want 0", rose); end
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", obs_in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc, prev, lat;
    logic [W-1:0] xv, yv;
    logic [GW-1:0] gv;
    res_t e;
    out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      xv = W'($urandom_range(0, 63));
      yv = W'($urandom_range(1, 1023));
      gv = GW'($urandom);
      exp_q.push_back(model(1'b0, xv, yv, gv));
      start_op(1'b0, xv, yv, gv, acc);
      if (prev >= 0) begin
        checks++; if (acc - prev != ITER + 3) begin errors++; $display("FAIL b2b_period[%0d] got %0d want %0d", i, acc - prev, ITER + 3); end
      end
      prev = acc;
      wait_result(lat);
      e = res_t'(exp_q.pop_front());
      checks++; if (obs !== e) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, obs, e); end
      finish_op(1'b1);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_unsigned_directed();
    test_backpressure();
    test_dbz();
    test_signed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
